// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch-stage control inputs, the instruction-memory port and the
// F-stage results into one interface.
//
// Signals (direction as seen by the fetch stage, modport slave):
//   in  en_f             F-stage enable (0 = stall, PC holds)
//   in  req              CP0 exception/interrupt request pulse
//   in  eret_d           eret currently in D
//   in  epc[31:0]        CP0 EPC value
//   in  ctrl_d           instruction in D is a branch/jump
//   in  branch_taken_d   D-stage branch condition true
//   in  branch_target_d  D-stage branch target
//   in  jump_d           D-stage j/jal
//   in  jump_target_d    j/jal target
//   in  jr_d             D-stage jr/jalr
//   in  jr_target_d      forwarded rs value
//   out i_inst_addr      instruction-memory address
//   in  i_inst_rdata     instruction-memory read data (combinational)
//   out pc_f             current fetch PC
//   out instruction_f    fetched instruction or 0
//   out exception_f      exception code (Int or AdEL)
//   out bd_f             fetched instruction is a delay slot
// The master modport is the mirror image, used by the surrounding pipeline.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
   logic        en_f;
   logic        req;
   logic        eret_d;
   logic [31:0] epc;
   logic        ctrl_d;
   logic        branch_taken_d;
   logic [31:0] branch_target_d;
   logic        jump_d;
   logic [31:0] jump_target_d;
   logic        jr_d;
   logic [31:0] jr_target_d;
   logic [31:0] i_inst_addr;
   logic [31:0] i_inst_rdata;
   logic [31:0] pc_f;
   logic [31:0] instruction_f;
   logic [4:0]  exception_f;
   logic        bd_f;

   modport slave (
      input  en_f, req, eret_d, epc, ctrl_d, branch_taken_d, branch_target_d,
             jump_d, jump_target_d, jr_d, jr_target_d, i_inst_rdata,
      output i_inst_addr, pc_f, instruction_f, exception_f, bd_f
   );

   modport master (
      output en_f, req, eret_d, epc, ctrl_d, branch_taken_d, branch_target_d,
             jump_d, jump_target_d, jr_d, jr_target_d, i_inst_rdata,
      input  i_inst_addr, pc_f, instruction_f, exception_f, bd_f
   );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// F-stage front end of the five-stage MIPS pipeline. Holds the fetch PC,
// picks the next PC (reset, exception entry, stall, eret, jr, j/jal, taken
// branch, sequential), drives the instruction-memory address and flags
// fetch address errors (AdEL).
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset (PC <= RESET_PC)
//   bus    fetch_stage_if.slave, see the interface file for its signals
//
// Build option:
//   FETCH_RANGE_CHECK_EN  when defined, aligned fetches outside
//                         [IM_BASE, IM_TOP] also raise AdEL; otherwise only
//                         misaligned fetches do.
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_BASE    = 32'h0000_3000,
   parameter logic [31:0] IM_TOP     = 32'h0000_6FFC,
   parameter logic [4:0]  EXC_INT    = 5'd0,
   parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
   input logic          clk,
   input logic          reset,
   fetch_stage_if.slave bus
);

`ifdef FETCH_RANGE_CHECK_EN
   localparam logic RangeCheckOn = 1'b1;
`else
   localparam logic RangeCheckOn = 1'b0;
`endif

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic        misaligned;
   logic        outOfRange;
   logic        addrError;

   // Next-PC selection. The exception request beats the stall because the
   // handler must be entered even while the pipeline is frozen; among the
   // D-stage redirects, eret beats jr beats j/jal beats a taken branch so
   // that an illegal overlap still resolves to a fixed answer.
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (bus.req) begin
         pc_d = HANDLER_PC;
      end else if (!bus.en_f) begin
         pc_d = pc_q;
      end else if (bus.eret_d) begin
         pc_d = bus.epc;
      end else if (bus.jr_d) begin
         pc_d = bus.jr_target_d;
      end else if (bus.jump_d) begin
         pc_d = bus.jump_target_d;
      end else if (bus.ctrl_d && bus.branch_taken_d) begin
         pc_d = bus.branch_target_d;
      end
   end

   // The PC register. Reset wins over every redirect, including req.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Fetch-address legality. An illegal PC is not corrected here; the
   // exception code travels down the pipe and CP0 answers with req.
   // The range term is a constant zero unless the range check is built in.
   always_comb begin
      misaligned = (pc_q[1:0] != 2'b00);
      outOfRange = RangeCheckOn && ((pc_q < IM_BASE) || (pc_q > IM_TOP));
      addrError  = misaligned || outOfRange;
   end

   // Outputs. Memory is still addressed with an illegal PC, but its data is
   // replaced by a nop so the faulting fetch cannot have side effects.
   always_comb begin
      bus.i_inst_addr   = pc_q;
      bus.pc_f          = pc_q;
      bus.bd_f          = bus.ctrl_d;
      bus.exception_f   = addrError ? EXC_ADEL : EXC_INT;
      bus.instruction_f = addrError ? 32'h0000_0000 : bus.i_inst_rdata;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F-stage front end of the P7 five-stage MIPS pipeline.
- Holds the architectural fetch PC and selects the next PC from sequential, branch/jump, eret and exception-entry sources.
- Drives the instruction-memory address and checks fetch-address legality (AdEL).
- Produces pc_f, instruction_f, exception_f and bd_f, which the F/D pipeline register latches into D.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_6FFC, highest legal fetch address.
- EXC_INT, 5'd0, "no exception" code (`Int`).
- EXC_ADEL, 5'd4, address-error-on-fetch code.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en_f  in  1  F-stage enable; 0 = stall, PC holds.
- req  in  1  CP0 exception/interrupt request, one-cycle pulse.
- eret_d  in  1  eret currently in D.
- epc  in  32  CP0 EPC value.
- ctrl_d  in  1  instruction in D is a branch/jump (any type).
- branch_taken_d  in  1  D-stage branch condition true.
- branch_target_d  in  32  D-stage branch target.
- jump_d  in  1  D-stage j/jal.
- jump_target_d  in  32  {pc_d+4[31:28], imm26, 2'b00}.
- jr_d  in  1  D-stage jr/jalr.
- jr_target_d  in  32  forwarded rs value.
- i_inst_addr  out  32  instruction-memory address (= pc_f).
- i_inst_rdata  in  32  instruction-memory read data, combinational.
- pc_f  out  32  current fetch PC.
- instruction_f  out  32  fetched instruction or 0.
- exception_f  out  5  EXC_INT or EXC_ADEL.
- bd_f  out  1  fetched instruction is a delay slot.

Behaviour:
- State: one 32-bit PC register. All outputs are combinational from PC and inputs.
- Reset: on posedge clk with reset=1, PC <= RESET_PC.
  - Resulting outputs: pc_f = 0x3000, instruction_f = i_inst_rdata, exception_f = EXC_INT.
- Next-PC priority, evaluated at posedge clk:
  1. reset → RESET_PC.
  2. req → HANDLER_PC. Overrides en_f=0.
  3. en_f=0 → hold PC.
  4. eret_d → epc. The instruction fetched this cycle is discarded by F/D.
  5. jr_d → jr_target_d.
  6. jump_d → jump_target_d.
  7. ctrl_d & branch_taken_d → branch_target_d.
  8. Otherwise → PC + 4. 32-bit add, wraps modulo 2^32, no overflow detection.
- Only one of eret_d/jr_d/jump_d/branch_taken_d is expected per cycle; the priority above resolves illegal overlap deterministically.
- bd_f = ctrl_d, combinational. It remains valid while stalled because D is frozen.
- AdEL condition (combinational on PC): PC[1:0] != 0, or (range check on, see Optional Feature) PC outside [IM_BASE, IM_TOP].
  - When set: exception_f = EXC_ADEL, instruction_f = 32'h0. i_inst_addr is still driven with PC; memory contents are ignored.
  - When clear: exception_f = EXC_INT, instruction_f = i_inst_rdata.
- Redirect to an illegal target (e.g. jr to 0x3001) raises AdEL on the following fetch. PC itself is not corrected; the handler redirect comes via req.
- Latency: a redirect requested in cycle N is visible on pc_f in cycle N+1.
- Reset mid-stall or concurrent with req: reset wins, PC = RESET_PC.
- req concurrent with eret_d: req wins.

Optional Feature:
- Macro FETCH_RANGE_CHECK_EN.
- Defined: AdEL also flags PC < IM_BASE or PC > IM_TOP.
- Undefined: only misalignment (PC[1:0] != 0) raises AdEL; out-of-range aligned fetches return i_inst_rdata with EXC_INT.

Test Plan:
- Reset held 2 cycles, then released with en_f=1 and no redirects → pc_f sequence 0x3000, 0x3004, 0x3008; exception_f = 0.
- At pc=0x3010: ctrl_d=1, branch_taken_d=1, branch_target_d=0x3100 → bd_f=1 that cycle; next pc_f = 0x3100.
- en_f=0 for 3 cycles at pc=0x3020 → pc_f stays 0x3020. Pulse req on the 2nd stall cycle → next pc_f = 0x4180.
- jr_d=1, jr_target_d=0x3002 → next cycle exception_f = 4, instruction_f = 0.
- eret_d=1 and jump_d=1, epc=0x3040, jump_target_d=0x3800 → next pc_f = 0x3040. Same cycle with req=1 added → next pc_f = 0x4180.
- With FETCH_RANGE_CHECK_EN: jump to 0x7000 → exception_f = 4. Without the macro → exception_f = 0, instruction_f = i_inst_rdata.
